// File: rtl/tt_um_uart_tx.sv
// Tiny Tapeout top: 8N1 UART transmitter, start strobe on uio_in[0], serial out on uo_out[0].
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module tt_um_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        tx;
  logic        busy;
  logic        done;
`ifdef UART_PARITY_EN
  logic        par;
`endif

  logic bit_end;
  assign bit_end = (baud_cnt == LAST_CNT);

  // Harness enable and the upper bidirectional inputs carry no function here.
  logic unused_inputs;
  assign unused_inputs = &{ena, uio_in[7:1], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef UART_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state != IDLE) begin
        baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
      end
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          // Start bit goes out on the same edge the request is seen.
          if (uio_in[0]) begin
            shreg   <= ui_in;
            bit_idx <= '0;
            state   <= START;
            tx      <= 1'b0;
            busy    <= 1'b1;
`ifdef UART_PARITY_EN
            par     <= ^ui_in;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              tx <= shreg[1];
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            tx    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign uo_out  = {5'b0, done, busy, tx};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_uart_tx.sv
// Scoreboard bench for tt_um_uart_tx: stimulus queues expected bytes, a line monitor decodes
// and checks each serial frame against a frame-level model. Build with CLKS_PER_BIT=4.
module tb_tt_um_uart_tx;

  localparam int C = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  wire tx   = uo_out[0];
  wire busy = uo_out[1];
  wire done = uo_out[2];

  typedef struct {
    logic [7:0] d;
    bit         abort;
  } exp_t;

  exp_t q[$];
  int   starts[$];
  int   cyc = 0;
  bit   in_frame = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
    logic [NB-1:0] b;
    int ones;
    ones = 0;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b[1+i] = d[i];
      if (d[i]) ones++;
    end
`ifdef UART_PARITY_EN
    b[9] = (ones % 2 == 1);
`endif
    b[NB-1] = 1'b1;
    return b;
  endfunction

  // Line monitor
  initial begin
    logic          prev;
    exp_t          e;
    logic [NB-1:0] fb;
    logic [7:0]    got;
    bit            aborted;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev === 1'b1 && tx === 1'b0) begin
        starts.push_back(cyc);
        in_frame = 1'b1;
        aborted  = 1'b0;
        got      = 8'h00;
        e.d      = 8'h00;
        e.abort  = 1'b0;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame: frame began at cycle %0d with no byte queued", cyc);
        end else begin
          e = q.pop_front();
        end
        fb = frame_bits(e.d);
        for (int k = 0; k <= NB*C && !aborted; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            check("abort_expected", {31'd0, e.abort}, 32'd1);
          end else if (k < NB*C) begin
            check("busy_in_frame", {31'd0, busy}, 32'd1);
            check("done_in_frame", {31'd0, done}, 32'd0);
            if (k % C == C/2) begin
              check($sformatf("frame_bit%0d", k/C), {31'd0, tx}, {31'd0, fb[k/C]});
              if (k/C >= 1 && k/C <= 8) got[k/C-1] = tx;
            end
          end else begin
            check("done_pulse", {31'd0, done}, 32'd1);
            check("busy_after_stop", {31'd0, busy}, 32'd0);
            check("tx_after_stop", {31'd0, tx}, 32'd1);
            check("data_byte", {24'd0, got}, {24'd0, e.d});
            check("abort_flag", {31'd0, e.abort}, 32'd0);
          end
        end
        in_frame = 1'b0;
        prev = tx;
      end else begin
        if (!rst) begin
          check("idle_busy", {31'd0, busy}, 32'd0);
          check("idle_done", {31'd0, done}, 32'd0);
        end
        prev = tx;
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit ab);
    exp_t e;
    e.d = d;
    e.abort = ab;
    q.push_back(e);
    @(posedge clk); #1;
    ui_in = d;
    uio_in[0] = 1'b1;
    @(posedge clk); #1;
    check("start_latency_tx", {31'd0, tx}, 32'd0);
    check("start_latency_busy", {31'd0, busy}, 32'd1);
    uio_in[0] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || in_frame) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (n >= 1000) begin
      n_fail++;
      $display("FAIL wait_idle: transmitter still busy after %0d cycles", n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1;
    uio_in = 8'h01;
    ui_in = 8'hAA;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_uio_oe", {24'd0, uio_oe}, 32'd0);
      check("rst_uio_out", {24'd0, uio_out}, 32'd0);
      check("rst_uo_hi", {27'd0, uo_out[7:3]}, 32'd0);
    end
    rst = 1'b0;
    uio_in = 8'h00;
    repeat (2) @(posedge clk);

    send(8'h55, 1'b0);
    wait_idle();

    // Data and start changes while busy must not disturb the frame.
    send(8'hA3, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    ui_in = 8'hFF;
    uio_in[0] = 1'b1;
    @(posedge clk); #1;
    uio_in[0] = 1'b0;
    wait_idle();
    check("no_extra_frame", q.size(), 32'd0);

    // Start held high: back-to-back frames with a single idle cycle between.
    base = starts.size();
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.d = 8'h0F;
      e.abort = 1'b0;
      q.push_back(e);
    end
    ui_in = 8'h0F;
    uio_in[0] = 1'b1;
    n = 0;
    while (starts.size() < base + 3 && n < 3*(NB*C+1) + 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    uio_in[0] = 1'b0;
    check("b2b_frames_seen", starts.size() - base, 32'd3);
    wait_idle();
    if (starts.size() >= base + 3) begin
      check("b2b_gap1", starts[base+1] - starts[base], NB*C + 1);
      check("b2b_gap2", starts[base+2] - starts[base+1], NB*C + 1);
    end

    // Reset mid-frame aborts it cleanly.
    send(8'h00, 1'b1);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (2*NB*C) @(posedge clk);
    check("abort_consumed", q.size(), 32'd0);
    send(8'h3C, 1'b0);
    wait_idle();

    for (int i = 0; i < 4; i++) begin
      send(8'($urandom_range(0, 255)), 1'b0);
      wait_idle();
    end

`ifdef UART_PARITY_EN
    send(8'h07, 1'b0);
    wait_idle();
    send(8'h03, 1'b0);
    wait_idle();
`endif

    check("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tt_um_uart_tx.md
Name: tt_um_uart_tx

Overview:
- Tiny Tapeout user-project top containing an 8N1 UART transmitter.
- Parallel byte on `ui_in` plus a start strobe on `uio_in[0]` produces a serial frame on `uo_out[0]`.
- Status outputs `busy` and `done` go to the dedicated outputs.
- Sits directly under the chip harness; no other submodules are required.

Parameters:
- CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- ena  input  1  harness enable; ignored by the logic.
- ui_in  input  8  transmit data byte, sampled when a frame is accepted.
- uio_in  input  8  bit0 = start request; bits 7:1 ignored.
- uo_out  output  8  bit0 = tx serial line, bit1 = busy, bit2 = done, bits 7:3 = 0.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0 (all bidirectional pins are inputs).

Behaviour:
- Outputs:
  - All outputs are registered except the constant zeros.
  - Reset values: tx=1, busy=0, done=0, state=IDLE, counters=0, shift register=0.
  - `rst` takes priority over everything; asserting it mid-frame aborts the frame and tx returns to 1 on the next edge.
- States: IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - tx=1, busy=0.
  - On a clock edge with start=1: latch `ui_in` into the shift register, clear the baud counter, clear the bit index, go to START.
  - tx drives 0 and busy=1 from that same edge, giving 1 cycle latency from the start sample to the start bit.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx = current LSB of the shift register; data is sent LSB first.
  - Each bit is held CLKS_PER_BIT cycles, then the register shifts right and the bit index increments.
  - After bit index 7 completes, go to STOP (or PARITY when the feature is enabled).
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the final cycle's edge: go to IDLE, busy→0, and done=1 for exactly one cycle.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps; a bit boundary is the edge where the counter equals CLKS_PER_BIT-1.
- Frame length is exactly 10×CLKS_PER_BIT cycles (11× with parity).
- busy is high for every cycle in which tx carries frame content.
- Start while busy is ignored; `ui_in` changes during a frame do not affect it.
- Start is level-sensitive, sampled only in IDLE:
  - if start is still high in the first IDLE cycle after done, a new frame is accepted there;
  - back-to-back frames therefore have one idle-high cycle between stop bit and next start bit.
- done and a new acceptance never occur on the same edge.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 latched data bits) for CLKS_PER_BIT cycles.
  - Frame is 11 bits.
- Undefined:
  - No PARITY state or parity logic is compiled.
  - 8N1 frame of 10 bits.

Test Plan (bench builds with CLKS_PER_BIT=4):
1. Reset: rst=1 for 3 cycles with start=1 → tx=1, busy=0, done=0, uio_oe=0x00, uo_out[7:3]=0.
2. Send 0x55 (pulse start 1 cycle):
   - tx low starting 1 cycle after the start sample;
   - sampling mid-bit gives bit sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop);
   - busy high for 40 cycles, then done high for exactly 1 cycle.
3. Send 0xA3, and change `ui_in` to 0xFF and pulse start again mid-frame → transmitted data bits remain 1,1,0,0,0,1,0,1; no second frame starts.
4. Hold start=1 continuously with ui_in=0x0F → consecutive frames separated by exactly one tx=1 idle cycle after each done pulse.
5. Assert rst at cycle 15 of a frame sending 0x00 → tx=1 and busy=0 on the next edge; no done pulse; next start sends a complete frame.
6. With UART_PARITY_EN, send 0x07 → parity bit = 1, frame is 44 cycles; send 0x03 → parity bit = 0.
